// File: rtl/cc_background_scroller.sv
// Scrolling background generator: shifts a pseudo-random obstacle/gap pattern
// through eight rows at a programmable rate until a collision freezes it.
//
// state | meaning
// IDLE  | rows, score and counter held at zero, waiting for start
// RUN   | counting clocks; a scroll happens each time the counter reaches PERIOD
// HIT   | collision seen; everything frozen until start returns to IDLE
module cc_background_scroller #(
  parameter int DATAWIDTH    = 8,  // only 8 is supported
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                    CC_BACKGROUND_SCROLLER_CLOCK_50,
  input  logic                    CC_BACKGROUND_SCROLLER_RESET_InLow,
  input  logic                    CC_BACKGROUND_SCROLLER_START_InLow,
  input  logic                    CC_BACKGROUND_SCROLLER_COLLISION_InLow,
  input  logic [PERIOD_WIDTH-1:0] CC_BACKGROUND_SCROLLER_PERIOD_InBUS,
  input  logic [7:0]              CC_BACKGROUND_SCROLLER_SEED_InBUS,
  output logic [DATAWIDTH-1:0]    CC_BACKGROUND_SCROLLER_BACK_OutBUS_u0,
  output logic [DATAWIDTH-1:0]    CC_BACKGROUND_SCROLLER_BACK_OutBUS_u1,
  output logic [DATAWIDTH-1:0]    CC_BACKGROUND_SCROLLER_BACK_OutBUS_u2,
  output logic [DATAWIDTH-1:0]    CC_BACKGROUND_SCROLLER_BACK_OutBUS_u3,
  output logic [DATAWIDTH-1:0]    CC_BACKGROUND_SCROLLER_BACK_OutBUS_u4,
  output logic [DATAWIDTH-1:0]    CC_BACKGROUND_SCROLLER_BACK_OutBUS_u5,
  output logic [DATAWIDTH-1:0]    CC_BACKGROUND_SCROLLER_BACK_OutBUS_u6,
  output logic [DATAWIDTH-1:0]    CC_BACKGROUND_SCROLLER_BACK_OutBUS_u7,
  output logic                    CC_BACKGROUND_SCROLLER_SCROLL_OutHigh,
  output logic [1:0]              CC_BACKGROUND_SCROLLER_STATE_OutBUS,
  output logic [7:0]              CC_BACKGROUND_SCROLLER_SCORE_OutBUS
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HIT  = 2'b10
  } state_t;

  state_t                        state_q, state_d;
  logic [PERIOD_WIDTH-1:0]       cnt_q, cnt_d;
  logic [7:0]                    lfsr_q, lfsr_d;
  logic [7:0]                    score_q, score_d;
  logic [7:0][DATAWIDTH-1:0]     rows_q, rows_d;
  logic                          scroll_q, scroll_d;

  logic                          start;
  logic                          collision;
  logic                          scroll_due;
  logic [DATAWIDTH-1:0]          new_row;
  logic [7:0]                    lfsr_next;

  assign start      = ~CC_BACKGROUND_SCROLLER_START_InLow;
  assign collision  = ~CC_BACKGROUND_SCROLLER_COLLISION_InLow;
  // >= rather than == so a PERIOD lowered below the running count fires at once
  assign scroll_due = (cnt_q >= CC_BACKGROUND_SCROLLER_PERIOD_InBUS);
  assign new_row    = score_q[0] ? '0 : (DATAWIDTH'(1) << lfsr_q[2:0]);
  assign lfsr_next  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge CC_BACKGROUND_SCROLLER_CLOCK_50 or negedge CC_BACKGROUND_SCROLLER_RESET_InLow) begin
    if (!CC_BACKGROUND_SCROLLER_RESET_InLow) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      lfsr_q   <= 8'h01;
      score_q  <= 8'h00;
      rows_q   <= '0;
      scroll_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      score_q  <= score_d;
      rows_q   <= rows_d;
      scroll_q <= scroll_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    score_d  = score_q;
    rows_d   = rows_q;
    scroll_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rows_d  = '0;
        cnt_d   = '0;
        score_d = 8'h00;
        if (start) begin
          state_d = ST_RUN;
          lfsr_d  = (CC_BACKGROUND_SCROLLER_SEED_InBUS == 8'h00) ? 8'h01
                                                                  : CC_BACKGROUND_SCROLLER_SEED_InBUS;
        end
      end
      ST_RUN: begin
        if (collision) begin
          // collision wins over a due scroll: nothing moves on this edge
          state_d = ST_HIT;
        end else if (scroll_due) begin
          rows_d   = {rows_q[6:0], new_row};
          score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          lfsr_d   = lfsr_next;
          cnt_d    = '0;
          scroll_d = 1'b1;
        end else begin
          cnt_d = cnt_q + PERIOD_WIDTH'(1);
        end
      end
      ST_HIT: begin
        if (start) begin
          state_d = ST_IDLE;
          rows_d  = '0;
          cnt_d   = '0;
          score_d = 8'h00;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rows_d  = '0;
        cnt_d   = '0;
        score_d = 8'h00;
      end
    endcase
  end

  assign CC_BACKGROUND_SCROLLER_BACK_OutBUS_u0   = rows_q[0];
  assign CC_BACKGROUND_SCROLLER_BACK_OutBUS_u1   = rows_q[1];
  assign CC_BACKGROUND_SCROLLER_BACK_OutBUS_u2   = rows_q[2];
  assign CC_BACKGROUND_SCROLLER_BACK_OutBUS_u3   = rows_q[3];
  assign CC_BACKGROUND_SCROLLER_BACK_OutBUS_u4   = rows_q[4];
  assign CC_BACKGROUND_SCROLLER_BACK_OutBUS_u5   = rows_q[5];
  assign CC_BACKGROUND_SCROLLER_BACK_OutBUS_u6   = rows_q[6];
  assign CC_BACKGROUND_SCROLLER_BACK_OutBUS_u7   = rows_q[7];
  assign CC_BACKGROUND_SCROLLER_SCROLL_OutHigh   = scroll_q;
  assign CC_BACKGROUND_SCROLLER_STATE_OutBUS     = state_q;
  assign CC_BACKGROUND_SCROLLER_SCORE_OutBUS     = score_q;

endmodule

// File: tb/tb_cc_background_scroller.sv
// Bench for cc_background_scroller: an arithmetic reference model checked
// every cycle, plus literal expectations at the documented checkpoints.
module tb_cc_background_scroller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_n;
  logic        coll_n;
  logic [23:0] period;
  logic [7:0]  seed;
  logic [7:0]  u0, u1, u2, u3, u4, u5, u6, u7;
  logic        scroll;
  logic [1:0]  state;
  logic [7:0]  score;

  int total = 0;
  int bad   = 0;

  // reference model: 0 idle, 1 run, 2 hit
  int m_state, m_cnt, m_lfsr, m_score, m_scroll;
  int m_rows[8];

  always #5 clk = ~clk;

  cc_background_scroller dut (
    .CC_BACKGROUND_SCROLLER_CLOCK_50       (clk),
    .CC_BACKGROUND_SCROLLER_RESET_InLow    (rst_n),
    .CC_BACKGROUND_SCROLLER_START_InLow    (start_n),
    .CC_BACKGROUND_SCROLLER_COLLISION_InLow(coll_n),
    .CC_BACKGROUND_SCROLLER_PERIOD_InBUS   (period),
    .CC_BACKGROUND_SCROLLER_SEED_InBUS     (seed),
    .CC_BACKGROUND_SCROLLER_BACK_OutBUS_u0 (u0),
    .CC_BACKGROUND_SCROLLER_BACK_OutBUS_u1 (u1),
    .CC_BACKGROUND_SCROLLER_BACK_OutBUS_u2 (u2),
    .CC_BACKGROUND_SCROLLER_BACK_OutBUS_u3 (u3),
    .CC_BACKGROUND_SCROLLER_BACK_OutBUS_u4 (u4),
    .CC_BACKGROUND_SCROLLER_BACK_OutBUS_u5 (u5),
    .CC_BACKGROUND_SCROLLER_BACK_OutBUS_u6 (u6),
    .CC_BACKGROUND_SCROLLER_BACK_OutBUS_u7 (u7),
    .CC_BACKGROUND_SCROLLER_SCROLL_OutHigh (scroll),
    .CC_BACKGROUND_SCROLLER_STATE_OutBUS   (state),
    .CC_BACKGROUND_SCROLLER_SCORE_OutBUS   (score)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_cnt   = 0;
    m_score = 0;
    for (int i = 0; i < 8; i++) m_rows[i] = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_state  = 0;
    m_lfsr   = 1;
    m_scroll = 0;
  endtask

  task automatic model_step();
    int row, fb;
    m_scroll = 0;
    if (!rst_n) begin
      model_reset();
    end else if (m_state == 0) begin
      model_clear();
      if (!start_n) begin
        m_state = 1;
        m_lfsr  = (seed == 0) ? 1 : int'(seed);
      end
    end else if (m_state == 1) begin
      if (!coll_n) begin
        m_state = 2;
      end else if (m_cnt >= int'(period)) begin
        row = (m_score % 2 == 0) ? (1 << (m_lfsr % 8)) : 0;
        for (int i = 7; i > 0; i--) m_rows[i] = m_rows[i-1];
        m_rows[0] = row;
        if (m_score < 255) m_score = m_score + 1;
        fb = ((m_lfsr / 128) + (m_lfsr / 32) + (m_lfsr / 16) + (m_lfsr / 8)) % 2;
        m_lfsr   = ((m_lfsr * 2) % 256) + fb;
        m_cnt    = 0;
        m_scroll = 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      if (!start_n) begin
        m_state = 0;
        model_clear();
      end
    end
  endtask

  task automatic compare();
    chk("state",  int'(state),  m_state);
    chk("scroll", int'(scroll), m_scroll);
    chk("score",  int'(score),  m_score);
    chk("u0", int'(u0), m_rows[0]);
    chk("u1", int'(u1), m_rows[1]);
    chk("u2", int'(u2), m_rows[2]);
    chk("u3", int'(u3), m_rows[3]);
    chk("u4", int'(u4), m_rows[4]);
    chk("u5", int'(u5), m_rows[5]);
    chk("u6", int'(u6), m_rows[6]);
    chk("u7", int'(u7), m_rows[7]);
  endtask

  // one clock: model follows the edge, outputs sampled 2ns later
  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
    compare();
  endtask

  task automatic pulse_start();
    start_n = 1'b0;
    tick();
    start_n = 1'b1;
  endtask

  initial begin
    model_reset();
    rst_n   = 1'b1;
    start_n = 1'b1;
    coll_n  = 1'b1;
    period  = 24'd3;
    seed    = 8'h01;
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("reset_state", int'(state), 0);
    chk("reset_u0", int'(u0), 0);
    chk("reset_score", int'(score), 0);
    rst_n = 1'b1;
    tick();

    // first scroll four clocks after start, then two more
    pulse_start();
    chk("start_state", int'(state), 1);
    repeat (3) tick();
    chk("pre_scroll", int'(scroll), 0);
    tick();
    chk("scroll1_pulse", int'(scroll), 1);
    chk("scroll1_u0", int'(u0), 8'h02);
    chk("scroll1_score", int'(score), 1);
    repeat (8) tick();
    chk("scroll3_pulse", int'(scroll), 1);
    chk("scroll3_u0", int'(u0), 8'h10);
    chk("scroll3_u1", int'(u1), 8'h00);
    chk("scroll3_u2", int'(u2), 8'h02);
    chk("scroll3_score", int'(score), 3);

    // start while running has no effect
    pulse_start();
    chk("start_ignored", int'(state), 1);

    // asynchronous reset mid-run clears outputs before any clock edge
    #3 rst_n = 1'b0;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_u2", int'(u2), 0);
    chk("async_score", int'(score), 0);
    tick();
    rst_n = 1'b1;
    pulse_start();
    repeat (4) tick();
    chk("rerun_u0", int'(u0), 8'h02);
    chk("rerun_score", int'(score), 1);

    // collision on the edge a scroll is due
    repeat (3) tick();
    coll_n = 1'b0;
    tick();
    coll_n = 1'b1;
    chk("hit_state", int'(state), 2);
    chk("hit_scroll", int'(scroll), 0);
    chk("hit_u0", int'(u0), 8'h02);
    chk("hit_score", int'(score), 1);
    repeat (5) tick();
    chk("frozen_score", int'(score), 1);
    pulse_start();
    chk("hit_to_idle", int'(state), 0);
    chk("idle_u1", int'(u1), 0);
    chk("idle_score", int'(score), 0);
    tick();
    chk("needs_second_start", int'(state), 0);

    // lowering PERIOD below the running count
    period = 24'd100;
    pulse_start();
    repeat (50) tick();
    chk("no_scroll_yet", int'(score), 0);
    period = 24'd2;
    tick();
    chk("lowered_scroll", int'(scroll), 1);
    chk("lowered_score", int'(score), 1);
    repeat (2) tick();
    chk("gap_scroll", int'(scroll), 0);
    tick();
    chk("period3_scroll", int'(scroll), 1);
    chk("period3_score", int'(score), 2);
    coll_n = 1'b0;
    tick();
    coll_n = 1'b1;
    pulse_start();

    // PERIOD=0 with zero seed: scroll every clock, score saturates
    seed   = 8'h00;
    period = 24'd0;
    pulse_start();
    tick();
    chk("fast_u0", int'(u0), 8'h02);
    chk("fast_scroll", int'(scroll), 1);
    repeat (299) tick();
    chk("sat_score", int'(score), 255);
    chk("sat_scroll", int'(scroll), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cc_background_scroller.md
CC_BACKGROUND_SCROLLER -- requirements
Module: CC_BACKGROUND_SCROLLER

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, row width; only 8 is supported.
REQ-002 SHALL have parameter PERIOD_WIDTH, default 24, width of the scroll-period bus.
REQ-003 SHALL have port CC_BACKGROUND_SCROLLER_CLOCK_50  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port CC_BACKGROUND_SCROLLER_RESET_InLow  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port CC_BACKGROUND_SCROLLER_START_InLow  input  1  start/restart request, active-low level, sampled each clock.
REQ-006 SHALL have port CC_BACKGROUND_SCROLLER_COLLISION_InLow  input  1  collision flag from the collision detector, active-low.
REQ-007 SHALL have port CC_BACKGROUND_SCROLLER_PERIOD_InBUS  input  PERIOD_WIDTH  scroll interval: one scroll per PERIOD+1 clocks.
REQ-008 SHALL have port CC_BACKGROUND_SCROLLER_SEED_InBUS  input  8  LFSR seed, loaded on start.
REQ-009 SHALL have ports CC_BACKGROUND_SCROLLER_BACK_OutBUS_u0..u7  output  DATAWIDTH each  background rows for the detector; u0 is the entry row.
REQ-010 SHALL have port CC_BACKGROUND_SCROLLER_SCROLL_OutHigh  output  1  one-clock pulse, registered, in the cycle the rows change.
REQ-011 SHALL have port CC_BACKGROUND_SCROLLER_STATE_OutBUS  output  2  current state: IDLE=00, RUN=01, HIT=10.
REQ-012 SHALL have port CC_BACKGROUND_SCROLLER_SCORE_OutBUS  output  8  count of completed scrolls since start.

Function
REQ-013 SHALL implement FSM IDLE/RUN/HIT; encoding 11 is unreachable and SHALL recover to IDLE on the next clock.
REQ-014 In IDLE: SHALL hold all rows at 0, counter at 0, and score at 0, and SHALL deassert SCROLL.
- IDLE->RUN when START_InLow=0.
- On that transition: LFSR <= SEED, or 8'h01 if SEED=0; counter <= 0.
REQ-015 In RUN: counter SHALL increment by 1 per clock.
- When counter >= PERIOD (unsigned compare, so a PERIOD lowered mid-run never wraps), a scroll SHALL occur and the counter SHALL reset to 0.
REQ-016 A scroll SHALL perform all of the following in the same clock edge:
- u7<=u6, ..., u1<=u0, u0<=new row (u7 is discarded).
- SCROLL_OutHigh=1 for that cycle.
- Score +1, saturating at 255.
- LFSR advances.
REQ-017 The new row SHALL depend on the score value before increment:
- Even score: obstacle row 8'h01 << LFSR[2:0].
- Odd score: gap row 8'h00.
REQ-018 LFSR SHALL advance as LFSR <= {LFSR[6:0], LFSR[7]^LFSR[5]^LFSR[4]^LFSR[3]}, once per scroll only.
REQ-019 PERIOD=0 SHALL give one scroll every clock in RUN.
REQ-020 RUN->HIT when COLLISION_InLow=0 at a clock edge.
- Collision has priority over a simultaneous scroll: no shift, no score increment, no SCROLL pulse on that edge.
REQ-021 In HIT: rows, score, counter and LFSR SHALL be frozen.
- HIT->IDLE when START_InLow=0; this clears rows, score and counter.
- A second START assertion is required to re-enter RUN.
REQ-022 START_InLow while in RUN SHALL be ignored.
REQ-023 All outputs SHALL be driven from registers; there SHALL be no combinational path from input to output.

Reset
REQ-024 RESET_InLow=0 SHALL immediately, independent of the clock, force:
- state IDLE;
- all rows 8'h00, score 0, counter 0;
- LFSR 8'h01;
- SCROLL 0.
REQ-025 Reset asserted mid-scroll or in HIT SHALL give the same result as REQ-024; operation SHALL resume on the first clock edge after release.

Verification
REQ-026 Reset then SEED=8'h01, PERIOD=3, START low 1 clk -> STATE=01; first SCROLL pulse 4 clocks later with u0=8'h02, score=1.
REQ-027 Continue REQ-026 for two more scrolls -> u0=8'h10, u1=8'h00, u2=8'h02, score=3, SCROLL pulse every 4th clock.
REQ-028 PERIOD=0, SEED=0, run 300 clocks without collision -> LFSR started at 8'h01, scroll every clock, score saturates at 255 and holds.
REQ-029 COLLISION_InLow=0 on the same edge as a due scroll -> STATE=10, rows and score unchanged, no SCROLL; later START -> STATE=00, all rows 0, score 0.
REQ-030 Assert RESET_InLow asynchronously mid-RUN with rows non-zero -> outputs 0 and STATE=00 before the next clock edge; START after release runs REQ-026 again.
REQ-031 Lower PERIOD from 100 to 2 while counter=50 -> scroll on the next edge, then every 3 clocks.
